// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// This package holds the reset PC, the fetch stride and the FSM state encoding.
package fetch_ctrl_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;
    localparam logic [31:0] FETCH_STRIDE     = 32'd4;

    typedef enum logic [2:0] {
        S_REQ     = 3'd0,
        S_WAIT    = 3'd1,
        S_HOLD    = 3'd2,
        S_DISCARD = 3'd3,
        S_ERR     = 3'd4
    } fetch_state_e;

    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// PC register with a clear/load path for redirects and an enable path for normal advance.
// When both paths are active, the redirect load (clr) takes priority over the advance.
module fetch_ctrl_pc #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] newpc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] pc_o
);

    logic [WIDTH-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr)
            pc_d = newpc;
        else if (en)
            pc_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_VAL;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. At most one fetch is outstanding at a time.
// Handles branch delay slots, exception/ERET redirects and misaligned-fetch reporting.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_pc_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        fetch_adel_o,
    output logic [31:0] fetch_badvaddr_o
);

    fetch_state_e state_q, state_d;
    logic         br_pend_q, br_pend_d;
    logic [31:0]  br_tgt_q, br_tgt_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         adel_q, adel_d;
    logic [31:0]  badvaddr_q, badvaddr_d;

    logic [31:0]  pc;
    logic         redirect, aligned, accept, advance;
    logic [31:0]  redir_pc, adv_pc;

    assign redirect = exc_valid_i | eret_i;
    assign redir_pc = exc_valid_i ? exc_pc_i : epc_i;
    assign aligned  = pc_aligned(pc[1:0]);
    assign accept   = (state_q == S_REQ) && aligned && inst_addr_ok_i;
    // Once the delay slot has been requested (we are in WAIT or HOLD), a pending
    // branch target replaces the PC immediately instead of waiting for the next accept.
    assign advance  = accept ||
                      (br_pend_q && ((state_q == S_WAIT) || (state_q == S_HOLD)));
    assign adv_pc   = br_pend_q ? br_tgt_q : pc + FETCH_STRIDE;

    fetch_ctrl_pc #(
        .WIDTH    (32),
        .RESET_VAL(RESET_PC)
    ) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en   (advance),
        .clr  (redirect),
        .newpc(redir_pc),
        .d    (adv_pc),
        .pc_o (pc)
    );

    always_comb begin
        state_d      = state_q;
        br_pend_d    = br_pend_q;
        br_tgt_d     = br_tgt_q;
        req_pc_d     = accept ? pc : req_pc_q;
        inst_valid_d = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        adel_d       = 1'b0;
        badvaddr_d   = badvaddr_q;

        if (redirect) begin
            br_pend_d = 1'b0;
        end else if (br_taken_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_target_i;
        end else if (advance) begin
            br_pend_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (redirect)
                    state_d = accept ? S_DISCARD : S_REQ;
                else if (!aligned) begin
                    adel_d     = 1'b1;
                    badvaddr_d = pc;
                    state_d    = S_ERR;
                end else if (inst_addr_ok_i)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect)
                    state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                else if (inst_data_ok_i) begin
                    inst_valid_d = 1'b1;
                    inst_d       = inst_rdata_i;
                    inst_pc_d    = req_pc_q;
                    state_d      = stall_i ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect || !stall_i)
                    state_d = S_REQ;
                else
                    inst_valid_d = 1'b1;
            end
            S_DISCARD: begin
                if (inst_data_ok_i)
                    state_d = S_REQ;
            end
            S_ERR: begin
                if (redirect)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            br_pend_q    <= 1'b0;
            br_tgt_q     <= '0;
            req_pc_q     <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            adel_q       <= 1'b0;
            badvaddr_q   <= '0;
        end else begin
            state_q      <= state_d;
            br_pend_q    <= br_pend_d;
            br_tgt_q     <= br_tgt_d;
            req_pc_q     <= req_pc_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            adel_q       <= adel_d;
            badvaddr_q   <= badvaddr_d;
        end
    end

    assign inst_req_o       = (state_q == S_REQ) && aligned;
    assign inst_addr_o      = pc;
    assign inst_valid_o     = inst_valid_q;
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;
    assign fetch_adel_o     = adel_q;
    assign fetch_badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl. Each row gives the inputs for one cycle
// and the outputs expected before that cycle's rising edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 0, br_taken_i = 0, exc_valid_i = 0, eret_i = 0;
    logic [31:0] br_target_i = 0, exc_pc_i = 0, epc_i = 0, inst_rdata_i = 0;
    logic        inst_addr_ok_i = 0, inst_data_ok_i = 0;
    logic        inst_req_o, inst_valid_o, fetch_adel_o;
    logic [31:0] inst_addr_o, inst_o, inst_pc_o, fetch_badvaddr_o;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i),
        .eret_i(eret_i), .epc_i(epc_i),
        .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
        .inst_rdata_i(inst_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .fetch_adel_o(fetch_adel_o), .fetch_badvaddr_o(fetch_badvaddr_o)
    );

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic        adel;
        logic [31:0] badv;
    } outs_t;

    typedef struct {
        logic        stall, br;
        logic [31:0] tgt;
        logic        exc;
        logic [31:0] excpc;
        logic        eret;
        logic [31:0] epc;
        logic        aok, dok;
        logic [31:0] rdata;
        outs_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   passed = 0;

    function automatic vec_t v(logic stall, logic br, logic [31:0] tgt, logic exc, logic [31:0] excpc,
                               logic eret, logic [31:0] epc, logic aok, logic dok, logic [31:0] rdata,
                               logic req, logic [31:0] addr, logic vld, logic [31:0] inst,
                               logic [31:0] ipc, logic adel, logic [31:0] badv);
        vec_t r;
        r.stall = stall; r.br = br; r.tgt = tgt; r.exc = exc; r.excpc = excpc;
        r.eret = eret; r.epc = epc; r.aok = aok; r.dok = dok; r.rdata = rdata;
        r.exp = '{req, addr, vld, inst, ipc, adel, badv};
        return r;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = '{inst_req_o, inst_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_adel_o, fetch_badvaddr_o};
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got req=%b addr=%h vld=%b inst=%h pc=%h adel=%b badv=%h, expected req=%b addr=%h vld=%b inst=%h pc=%h adel=%b badv=%h",
                     name, got.req, got.addr, got.vld, got.inst, got.ipc, got.adel, got.badv,
                     exp.req, exp.addr, exp.vld, exp.inst, exp.ipc, exp.adel, exp.badv);
    endtask

    task automatic drive(input vec_t r);
        stall_i = r.stall; br_taken_i = r.br; br_target_i = r.tgt;
        exc_valid_i = r.exc; exc_pc_i = r.excpc; eret_i = r.eret; epc_i = r.epc;
        inst_addr_ok_i = r.aok; inst_data_ok_i = r.dok; inst_rdata_i = r.rdata;
    endtask

    localparam logic [31:0] B = 32'hBFC00000;
    localparam logic [31:0] X = 32'hBFC00380;
    localparam logic [31:0] M = 32'h80000002;

    initial begin
        //          stall br tgt         exc excpc eret epc           aok dok rdata          req addr         vld inst           ipc            adel badv
        // sequential fetch
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, B,           0, 0,             0,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h11111111,  0, B+4,         0, 0,             0,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, B+4,         1, 32'h11111111,  B,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h22222222,  0, B+8,         0, 32'h11111111,  B,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, B+8,         1, 32'h22222222,  B+4,           0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h33333333,  0, B+12,        0, 32'h22222222,  B+4,           0, 0));
        // branch while delay slot B+C is in flight
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, B+12,        1, 32'h33333333,  B+8,           0, 0));
        vecs.push_back(v(0, 1, B+32'h100, 0, 0,    0, 0,            0, 0, 0,             0, B+16,        0, 32'h33333333,  B+8,           0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             0, B+16,        0, 32'h33333333,  B+8,           0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h44444444,  0, B+32'h100,   0, 32'h33333333,  B+8,           0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, B+32'h100,   1, 32'h44444444,  B+12,          0, 0));
        // exception while in WAIT: stale response dropped
        vecs.push_back(v(0, 0, 0,         1, X,    0, 0,            0, 0, 0,             0, B+32'h104,   0, 32'h44444444,  B+12,          0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'hDEADBEEF,  0, X,           0, 32'h44444444,  B+12,          0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, X,           0, 32'h44444444,  B+12,          0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h55555555,  0, X+4,         0, 32'h44444444,  B+12,          0, 0));
        // exception and eret together: exception wins
        vecs.push_back(v(0, 0, 0,         1, X,    1, 32'h80001000, 0, 0, 0,             1, X+4,         1, 32'h55555555,  X,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             1, X,           0, 32'h55555555,  X,             0, 0));
        // stall for three cycles at data_ok
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, X,           0, 32'h55555555,  X,             0, 0));
        vecs.push_back(v(1, 0, 0,         0, 0,    0, 0,            0, 1, 32'h66666666,  0, X+4,         0, 32'h55555555,  X,             0, 0));
        vecs.push_back(v(1, 0, 0,         0, 0,    0, 0,            1, 0, 0,             0, X+4,         1, 32'h66666666,  X,             0, 0));
        vecs.push_back(v(1, 0, 0,         0, 0,    0, 0,            1, 0, 0,             0, X+4,         1, 32'h66666666,  X,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             0, X+4,         1, 32'h66666666,  X,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             1, X+4,         0, 32'h66666666,  X,             0, 0));
        // eret to misaligned address
        vecs.push_back(v(0, 0, 0,         0, 0,    1, M,            0, 0, 0,             1, X+4,         0, 32'h66666666,  X,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             0, M,           0, 32'h66666666,  X,             0, 0));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             0, M,           0, 32'h66666666,  X,             1, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             0, M,           0, 32'h66666666,  X,             0, M));
        vecs.push_back(v(0, 0, 0,         1, X,    0, 0,            0, 0, 0,             0, M,           0, 32'h66666666,  X,             0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             1, X,           0, 32'h66666666,  X,             0, M));
        // redirect coinciding with data_ok in WAIT
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, X,           0, 32'h66666666,  X,             0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    1, 32'h80000040, 0, 1, 32'h77777777,  0, X+4,         0, 32'h66666666,  X,             0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, 32'h80000040,0, 32'h66666666,  X,             0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h88888888,  0, 32'h80000044,0, 32'h66666666,  X,             0, M));
        // redirect in REQ together with addr_ok: DISCARD
        vecs.push_back(v(0, 0, 0,         1, X,    0, 0,            1, 0, 0,             1, 32'h80000044,1, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             0, X,           0, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'h99999999,  0, X,           0, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             1, X,           0, 32'h88888888,  32'h80000040,  0, M));
        // PC wraps past the top of the address space
        vecs.push_back(v(0, 0, 0,         0, 0,    1, 32'hFFFFFFFC, 0, 0, 0,             1, X,           0, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            1, 0, 0,             1, 32'hFFFFFFFC,0, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 1, 32'hAAAAAAAA,  0, 0,           0, 32'h88888888,  32'h80000040,  0, M));
        vecs.push_back(v(0, 0, 0,         0, 0,    0, 0,            0, 0, 0,             1, 0,           1, 32'hAAAAAAAA,  32'hFFFFFFFC,  0, M));

        repeat (2) @(posedge clk);
        #1 check("reset_state", '{1'b1, B, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1 check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // asynchronous reset while a fetch is outstanding, then a late data_ok
        @(negedge clk);
        drive(v(0,0,0,0,0,0,0, 1,0,0, 0,0,0,0,0,0,0));
        #1 check("pre_reset_req", '{1'b1, 32'h0, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFC, 1'b0, M});
        @(negedge clk);
        inst_addr_ok_i = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("async_reset", '{1'b1, B, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
        inst_data_ok_i = 1'b1; inst_rdata_i = 32'h12345678;
        @(negedge clk);
        inst_data_ok_i = 1'b0;
        #1 check("late_data_ok_ignored", '{1'b1, B, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
        inst_addr_ok_i = 1'b1;
        @(negedge clk);
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hCAFEF00D;
        @(negedge clk);
        inst_data_ok_i = 1'b0;
        #1 check("fetch_after_reset", '{1'b1, B+4, 1'b1, 32'hCAFEF00D, B, 1'b0, 32'h0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
